// File: rtl/riscv_i32_pkg.sv
// Shared RISC-V RV32I definitions: CSR addresses, mcause codes and the trap sequencer state type.
package riscv_i32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CAUSE_W = 4;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_PC = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL       = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT    = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL         = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } t_trap_seq_state;

endpackage

// File: rtl/riscv_i32_trap_vector.sv
// Trap target computation: direct base, or base + 4*cause for interrupts in vectored mode.
module riscv_i32_trap_vector
    import riscv_i32_pkg::*;
(
    input  logic [XLEN-1:0]    mtvec,
    input  logic [CAUSE_W-1:0] cause,
    input  logic               interrupt,
    output logic [XLEN-1:0]    vector_c
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    always_comb begin
        base   = {mtvec[XLEN-1:2], 2'b00};
        offset = XLEN'({cause, 2'b00});
        // Modes 2 and 3 are reserved and fall back to direct.
        if (mtvec[1:0] == 2'b01 && interrupt) begin
            vector_c = base + offset;
        end else begin
            vector_c = base;
        end
    end

endmodule

// File: rtl/riscv_i32_trap_sequencer.sv
// Machine-mode trap CSRs plus a held fetch-redirect handshake and debug-halt parking.
module riscv_i32_trap_sequencer
    import riscv_i32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter logic [31:0] MTVEC_RESET  = 32'h0,
    parameter bit          DEBUG_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        control_flow__trap__valid,
    input  logic        control_flow__trap__ret,
    input  logic [3:0]  control_flow__trap__cause,
    input  logic [31:0] control_flow__trap__pc,
    input  logic [31:0] control_flow__trap__value,
    input  logic        control_flow__trap__ebreak_to_dbg,
    input  logic        control_flow__async_cancel,
    input  logic        csr_write_valid,
    input  logic [11:0] csr_write_address,
    input  logic [31:0] csr_write_data,
    input  logic [11:0] csr_read_address,
    output logic [31:0] csr_read_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        trap_ready,
    output logic        interrupt_enable,
    output logic        halted,
    input  logic        debug_resume
);

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(1);

    t_trap_seq_state state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] vector;

    riscv_i32_trap_vector u_vector (
        .mtvec     (mtvec_q),
        .cause     (control_flow__trap__cause),
        .interrupt (control_flow__async_cancel),
        .vector_c  (vector)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_REDIRECT;
            redirect_pc_q <= RESET_VECTOR;
            mtvec_q       <= MTVEC_RESET;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;

        // CSR writes go first so a same-cycle trap/ret update overrides them.
        if (csr_write_valid) begin
            case (csr_write_address)
                CSR_MSTATUS: begin
                    mie_d  = csr_write_data[MSTATUS_MIE_BIT];
                    mpie_d = csr_write_data[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:  mtvec_d  = csr_write_data;
                CSR_MEPC:   mepc_d   = csr_write_data & PC_ALIGN_MASK;
                CSR_MCAUSE: mcause_d = csr_write_data;
                CSR_MTVAL:  mtval_d  = csr_write_data;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (control_flow__trap__valid) begin
                    mepc_d   = control_flow__trap__pc & PC_ALIGN_MASK;
                    mcause_d = {control_flow__async_cancel, 27'b0, control_flow__trap__cause};
                    mtval_d  = control_flow__trap__value;
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                    if (control_flow__trap__ebreak_to_dbg && DEBUG_ENABLE) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d       = ST_REDIRECT;
                        redirect_pc_d = vector;
                    end
                end else if (control_flow__trap__ret) begin
                    mie_d         = mpie_q;
                    mpie_d        = 1'b1;
                    redirect_pc_d = mepc_q;
                    state_d       = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ack) state_d = ST_IDLE;
            end
            ST_HALTED: begin
                if (debug_resume) begin
                    redirect_pc_d = mepc_q;
                    state_d       = ST_REDIRECT;
                end
            end
            default: state_d = ST_REDIRECT;
        endcase
    end

    always_comb begin
        csr_read_data = '0;
        case (csr_read_address)
            CSR_MSTATUS: begin
                csr_read_data[MSTATUS_MIE_BIT]  = mie_q;
                csr_read_data[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MTVEC:  csr_read_data = mtvec_q;
            CSR_MEPC:   csr_read_data = mepc_q;
            CSR_MCAUSE: csr_read_data = mcause_q;
            CSR_MTVAL:  csr_read_data = mtval_q;
            default: ;
        endcase
    end

    assign redirect_valid   = (state_q == ST_REDIRECT);
    assign redirect_pc      = redirect_pc_q;
    assign trap_ready       = (state_q == ST_IDLE);
    assign halted           = (state_q == ST_HALTED);
    assign interrupt_enable = mie_q;

endmodule
